// File: rtl/water_level_filter.sv
// Stability filter for the bottle water-level bus: commits a level after STABLE_COUNT equal samples.
// Optional sensor-unstable detector enabled by defining WLF_FAULT_EN.
module water_level_filter #(
    parameter int WIDTH        = 4,
    parameter int STABLE_COUNT = 4,
    parameter int SAMPLE_DIV   = 1,
    parameter int FAULT_TICKS  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level_in,
    output logic [WIDTH-1:0] level_out,
    output logic             level_valid,
    output logic             change_pulse,
    output logic             rise_pulse,
    output logic             drop_pulse,
    output logic [WIDTH-1:0] drop_amount,
    output logic             sample_tick,
    output logic             fault
);

    localparam int DIV_W = ($clog2(SAMPLE_DIV + 1) < 1) ? 1 : $clog2(SAMPLE_DIV + 1);
    localparam int CNT_W = ($clog2(STABLE_COUNT + 1) < 1) ? 1 : $clog2(STABLE_COUNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_COUNT);

    if (STABLE_COUNT < 1 || SAMPLE_DIV < 1 || FAULT_TICKS < 1) begin : g_bad_params
        $error("water_level_filter: STABLE_COUNT, SAMPLE_DIV and FAULT_TICKS must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             tick;
    logic             commit;

    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        next_cnt = CNT_W'(1);
        if (level_in == candidate) begin
            next_cnt = (stable_cnt >= CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
        end
        commit = tick && (next_cnt == CNT_MAX) && ((level_in != level_out) || !level_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= tick;
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            candidate    <= '0;
            stable_cnt   <= '0;
            level_out    <= '0;
            level_valid  <= 1'b0;
            change_pulse <= 1'b0;
            rise_pulse   <= 1'b0;
            drop_pulse   <= 1'b0;
            drop_amount  <= '0;
        end else begin
            change_pulse <= 1'b0;
            rise_pulse   <= 1'b0;
            drop_pulse   <= 1'b0;
            if (tick) begin
                candidate  <= level_in;
                stable_cnt <= next_cnt;
                if (commit) begin
                    level_out    <= level_in;
                    level_valid  <= 1'b1;
                    change_pulse <= 1'b1;
                    // once valid, a commit always differs from level_out, so it is a rise or a drop
                    if (level_valid) begin
                        if (level_in > level_out) begin
                            rise_pulse <= 1'b1;
                        end else begin
                            drop_pulse  <= 1'b1;
                            drop_amount <= level_out - level_in;
                        end
                    end
                end
            end
        end
    end

`ifdef WLF_FAULT_EN
    localparam int FLT_W = ($clog2(FAULT_TICKS + 1) < 1) ? 1 : $clog2(FAULT_TICKS + 1);
    localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(FAULT_TICKS);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FAULT_TICKS - 1);

    logic [FLT_W-1:0] unstable_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            unstable_cnt <= '0;
            fault        <= 1'b0;
        end else if (tick) begin
            if (next_cnt == CNT_MAX) begin
                unstable_cnt <= '0;
                fault        <= 1'b0;
            end else if (unstable_cnt != FLT_MAX) begin
                unstable_cnt <= unstable_cnt + 1'b1;
                if (unstable_cnt == FLT_LAST) begin
                    fault <= 1'b1;
                end
            end
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_water_level_filter.sv
// Self-checking bench: two filter configurations checked every cycle against a sliding-window model.
module tb_water_level_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] level_in = 4'd0;

    logic [3:0] a_out, a_amt, b_out, b_amt;
    logic a_valid, a_chg, a_rise, a_drop, a_tick, a_fault;
    logic b_valid, b_chg, b_rise, b_drop, b_tick, b_fault;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    water_level_filter #(.WIDTH(4), .STABLE_COUNT(4), .SAMPLE_DIV(1), .FAULT_TICKS(8)) dut_a (
        .clk(clk), .reset(reset), .level_in(level_in),
        .level_out(a_out), .level_valid(a_valid), .change_pulse(a_chg),
        .rise_pulse(a_rise), .drop_pulse(a_drop), .drop_amount(a_amt),
        .sample_tick(a_tick), .fault(a_fault)
    );

    water_level_filter #(.WIDTH(4), .STABLE_COUNT(2), .SAMPLE_DIV(3), .FAULT_TICKS(64)) dut_b (
        .clk(clk), .reset(reset), .level_in(level_in),
        .level_out(b_out), .level_valid(b_valid), .change_pulse(b_chg),
        .rise_pulse(b_rise), .drop_pulse(b_drop), .drop_amount(b_amt),
        .sample_tick(b_tick), .fault(b_fault)
    );

    // Behavioural model: per instance, keep the last samples taken since reset and
    // commit when the newest STABLE_COUNT of them are all equal.
    int         sd[2] = '{1, 3};
    int         sc[2] = '{4, 2};
    int         ft[2] = '{8, 64};
    int         n[2];
    int         nsamp[2];
    int         urun[2];
    logic [3:0] win[2][8];
    logic [3:0] m_out[2], m_amt[2];
    logic       m_valid[2], m_chg[2], m_rise[2], m_drop[2], m_tick[2], m_fault[2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                n[i] = 0; nsamp[i] = 0; urun[i] = 0;
                m_out[i] = 4'd0; m_amt[i] = 4'd0; m_valid[i] = 1'b0;
                m_chg[i] = 1'b0; m_rise[i] = 1'b0; m_drop[i] = 1'b0;
                m_tick[i] = 1'b0; m_fault[i] = 1'b0;
                for (int k = 0; k < 8; k++) win[i][k] = 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit tk_now;
                bit stable;
                n[i] = n[i] + 1;
                m_chg[i] = 1'b0; m_rise[i] = 1'b0; m_drop[i] = 1'b0;
                tk_now = ((n[i] % sd[i]) == 0);
                m_tick[i] = tk_now;
                if (tk_now) begin
                    for (int k = 7; k > 0; k--) win[i][k] = win[i][k-1];
                    win[i][0] = level_in;
                    if (nsamp[i] < 8) nsamp[i] = nsamp[i] + 1;
                    stable = (nsamp[i] >= sc[i]);
                    for (int k = 1; k < sc[i]; k++)
                        if (win[i][k] != win[i][0]) stable = 1'b0;
                    if (stable && (level_in != m_out[i] || !m_valid[i])) begin
                        m_chg[i] = 1'b1;
                        if (m_valid[i]) begin
                            if (level_in > m_out[i]) m_rise[i] = 1'b1;
                            else begin
                                m_drop[i] = 1'b1;
                                m_amt[i] = m_out[i] - level_in;
                            end
                        end
                        m_out[i] = level_in;
                        m_valid[i] = 1'b1;
                    end
`ifdef WLF_FAULT_EN
                    if (stable) begin
                        urun[i] = 0;
                        m_fault[i] = 1'b0;
                    end else begin
                        if (urun[i] < ft[i]) urun[i] = urun[i] + 1;
                        if (urun[i] >= ft[i]) m_fault[i] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("a.level_out", a_out, m_out[0]);
        chk("a.level_valid", a_valid, m_valid[0]);
        chk("a.change", a_chg, m_chg[0]);
        chk("a.rise", a_rise, m_rise[0]);
        chk("a.drop", a_drop, m_drop[0]);
        chk("a.drop_amount", a_amt, m_amt[0]);
        chk("a.sample_tick", a_tick, m_tick[0]);
        chk("a.fault", a_fault, m_fault[0]);
        chk("b.level_out", b_out, m_out[1]);
        chk("b.level_valid", b_valid, m_valid[1]);
        chk("b.change", b_chg, m_chg[1]);
        chk("b.rise", b_rise, m_rise[1]);
        chk("b.drop", b_drop, m_drop[1]);
        chk("b.drop_amount", b_amt, m_amt[1]);
        chk("b.sample_tick", b_tick, m_tick[1]);
        chk("b.fault", b_fault, m_fault[1]);
    end

    task automatic tk(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hold;
        int c;

        // reset state, then 9 held: first commit on the 4th tick
        level_in = 4'd9;
        tk(2);
        chk("rst.level_out", a_out, 0);
        chk("rst.valid", a_valid, 0);
        reset = 1'b1;
        tk(3);
        chk("d1.not_yet", a_valid, 0);
        tk(1);
        chk("d1.level_out", a_out, 9);
        chk("d1.valid", a_valid, 1);
        chk("d1.change", a_chg, 1);
        chk("d1.rise", a_rise, 0);
        chk("d1.drop", a_drop, 0);
        tk(1);
        chk("d1.change_end", a_chg, 0);

        // drop 9 -> 5
        level_in = 4'd5;
        tk(3);
        chk("d2.not_yet", a_out, 9);
        tk(1);
        chk("d2.level_out", a_out, 5);
        chk("d2.drop", a_drop, 1);
        chk("d2.amount", a_amt, 4);
        chk("d2.change", a_chg, 1);

        // 7/5 toggling never commits, then 7 held rises
        for (int i = 0; i < 8; i++) begin
            level_in = (i % 2 == 0) ? 4'd7 : 4'd5;
            tk(1);
            chk("d3.no_change", a_chg, 0);
        end
        chk("d3.held", a_out, 5);
        level_in = 4'd7;
        tk(3);
        chk("d3.not_yet", a_rise, 0);
        tk(1);
        chk("d3.rise", a_rise, 1);
        chk("d3.level_out", a_out, 7);
        chk("d3.amount", a_amt, 4);

        // divided sampling (instance b): ticks at edges 3, 6, 9, 12
        reset = 1'b0;
        level_in = 4'd3;
        tk(2);
        reset = 1'b1;
        tk(2);
        chk("d4.tick_off", b_tick, 0);
        tk(1);
        chk("d4.tick_on", b_tick, 1);
        tk(2);
        chk("d4.not_yet", b_valid, 0);
        tk(1);
        chk("d4.level_out", b_out, 3);
        chk("d4.change", b_chg, 1);
        level_in = 4'd0;
        tk(2);
        level_in = 4'd3;
        tk(4);
        chk("d4.glitch_ignored", b_out, 3);

        // reset mid-count discards partial samples; next commit is a first commit
        reset = 1'b0;
        tk(2);
        reset = 1'b1;
        level_in = 4'd12;
        tk(3);
        reset = 1'b0;
        tk(1);
        chk("d5.in_reset", a_valid, 0);
        tk(1);
        reset = 1'b1;
        tk(3);
        chk("d5.not_yet", a_valid, 0);
        tk(1);
        chk("d5.level_out", a_out, 12);
        chk("d5.change", a_chg, 1);
        chk("d5.rise", a_rise, 0);
        chk("d5.drop", a_drop, 0);

`ifdef WLF_FAULT_EN
        // 2/1 toggling for 8 ticks raises fault; 2 held clears it with the commit
        reset = 1'b0;
        tk(1);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            level_in = (i % 2 == 0) ? 4'd2 : 4'd1;
            tk(1);
            if (i == 6) chk("d6.fault_pre", a_fault, 0);
        end
        chk("d6.fault_set", a_fault, 1);
        level_in = 4'd2;
        tk(3);
        chk("d6.fault_hold", a_fault, 1);
        tk(1);
        chk("d6.fault_clear", a_fault, 0);
        chk("d6.level_out", a_out, 2);
`endif

        // randomized runs with held values and occasional resets
        c = 0;
        while (c < 3000) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                tk($urandom_range(1, 2));
                reset = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) level_in = 4'($urandom_range(0, 15));
            else level_in = 4'($urandom_range(2, 5));
            hold = $urandom_range(1, 7);
            tk(hold);
            c += hold;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
